// File: rtl/uart_sched_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_sched_pkg
// Brief    : Shared state encodings and defaults for the UART port scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package uart_sched_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_CLR  = 2'd1,
        RX_HOLD = 2'd2
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick, scanning upward from last+1.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = '0;
        for (int k = 1; k <= N; k++) begin
            w_pos = IW'((32'(i_last) + 32'(k)) % 32'(N));
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_port_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_port_sched
// Brief    : Round-robin TX sharing of one uart plus a one-entry RX buffer.
// Revision : 1.0 - initial release
// ============================================================================
module uart_port_sched
    import uart_sched_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                      clk_50m,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic [DATA_W-1:0]         uart_din,
    output logic                      uart_wr_en,
    input  logic                      uart_tx_busy,
    input  logic                      uart_rdy,
    input  logic [DATA_W-1:0]         uart_dout,
    output logic                      uart_rdy_clr,
    output logic                      rx_valid,
    output logic [DATA_W-1:0]         rx_data,
    input  logic                      rx_ready,
    output logic                      rx_overrun
);

    localparam int IW = $clog2(N_REQ);

    tx_state_e          r_tx_state, w_tx_next;
    rx_state_e          r_rx_state, w_rx_next;
    logic [IW-1:0]      r_last, r_grant_id;
    logic [DATA_W-1:0]  r_din, r_rx_data, w_sel_byte;
    logic               r_rx_valid, r_rx_overrun;
    logic [N_REQ-1:0]   w_gnt;
    logic [IW-1:0]      w_idx;
    logic               w_any, w_accept, w_capture;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .i_req  (req_valid),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    always_comb begin
        w_sel_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) w_sel_byte = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign w_accept  = (r_tx_state == IDLE) && w_any;
    assign w_capture = (r_rx_state == RX_IDLE) && uart_rdy;

    // ---------------- TX FSM ----------------
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) r_tx_state <= IDLE;
        else        r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            IDLE:       if (w_any)         w_tx_next = ISSUE;
            ISSUE:                         w_tx_next = WAIT_START;
            WAIT_START: if (uart_tx_busy)  w_tx_next = WAIT_DONE;
            WAIT_DONE:  if (!uart_tx_busy) w_tx_next = IDLE;
            default:                       w_tx_next = IDLE;
        endcase
    end

    // Ready is gated by rst_n so nothing can look accepted while reset is held.
    always_comb begin
        req_ready  = '0;
        uart_wr_en = 1'b0;
        if (rst_n && (r_tx_state == IDLE)) req_ready = w_gnt;
        if (r_tx_state == ISSUE)           uart_wr_en = 1'b1;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= IW'(N_REQ - 1);
            r_grant_id <= '0;
            r_din      <= '0;
        end else if (w_accept) begin
            r_last     <= w_idx;
            r_grant_id <= w_idx;
            r_din      <= w_sel_byte;
        end
    end

    assign grant_id = r_grant_id;
    assign uart_din = r_din;

    // ---------------- RX FSM ----------------
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE: if (uart_rdy) w_rx_next = RX_CLR;
            RX_CLR:                w_rx_next = RX_HOLD;
            RX_HOLD:               w_rx_next = RX_IDLE;
            default:               w_rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        uart_rdy_clr = (r_rx_state == RX_CLR);
    end

    // A capture always wins over a same-cycle consume; overrun only if unconsumed.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_valid   <= 1'b0;
            r_rx_data    <= '0;
            r_rx_overrun <= 1'b0;
        end else if (w_capture) begin
            r_rx_data  <= uart_dout;
            r_rx_valid <= 1'b1;
            if (r_rx_valid && !rx_ready) r_rx_overrun <= 1'b1;
        end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign rx_valid   = r_rx_valid;
    assign rx_data    = r_rx_data;
    assign rx_overrun = r_rx_overrun;

endmodule
`default_nettype wire
